mp_add_sequencer: RTL and testbench

MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

---
 rtl/mp_add_sequencer.sv | 134 +++++++++++++
 tb/tb_mp_add_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder sequencer: walks two NIBBLES-digit operands through an
// external 4-bit adder of latency ADD_LAT, one nibble slot at a time, LSB first.
module mp_add_sequencer #(
   parameter int NIBBLES = 4,
   parameter int ADD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic [3:0]           add_x,
   output logic [3:0]           add_y,
   output logic                 add_cin,
   input  logic [3:0]           add_z,
   input  logic                 add_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 carry,
   output logic                 busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NIBBLES - 1);
   localparam logic [2:0]       WAIT_LAST = (ADD_LAT > 0) ? 3'(ADD_LAT - 1) : 3'd0;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [IDX_W+1:0] bit_base;
   logic             slot_end;

   assign bit_base = {idx_q, 2'b00};

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      slot_end = 1'b0;
      in_ready = 1'b0;
      add_x    = 4'd0;
      add_y    = 4'd0;
      add_cin  = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            add_x   = a_q[bit_base +: 4];
            add_y   = b_q[bit_base +: 4];
            add_cin = carry_q;
            // A zero-latency adder answers in the issue cycle itself.
            if (ADD_LAT == 0) begin
               slot_end = 1'b1;
            end else begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            add_x   = a_q[bit_base +: 4];
            add_y   = b_q[bit_base +: 4];
            add_cin = carry_q;
            if (cnt_q == WAIT_LAST) slot_end = 1'b1;
            else                    cnt_d = cnt_q + 3'd1;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Adder outputs are only trusted on the last edge of a nibble slot.
      if (slot_end) begin
         sum_d[bit_base +: 4] = add_z;
         carry_d              = add_cout;
         if (idx_q == IDX_LAST) begin
            state_d = DONE;
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
         end
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench: default sequencer against a 2-cycle pipelined 4-bit adder
// model, plus a NIBBLES=2 / ADD_LAT=0 instance against a combinational adder.
module tb_mp_add_sequencer;

   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // instance 0: NIBBLES=4, ADD_LAT=2
   logic        in_valid0, in_ready0, cin0, add_cin0, add_cout0;
   logic        out_valid0, out_ready0, carry0, busy0;
   logic [15:0] a0, b0, sum0;
   logic [3:0]  add_x0, add_y0, add_z0;

   // instance 1: NIBBLES=2, ADD_LAT=0
   logic        in_valid1, in_ready1, cin1, add_cin1, add_cout1;
   logic        out_valid1, out_ready1, carry1, busy1;
   logic [7:0]  a1, b1, sum1;
   logic [3:0]  add_x1, add_y1, add_z1;

   mp_add_sequencer #(.NIBBLES(4), .ADD_LAT(2)) dut0 (
      .clk(clk), .res(res), .in_valid(in_valid0), .in_ready(in_ready0),
      .a(a0), .b(b0), .cin(cin0), .add_x(add_x0), .add_y(add_y0),
      .add_cin(add_cin0), .add_z(add_z0), .add_cout(add_cout0),
      .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
      .carry(carry0), .busy(busy0));

   mp_add_sequencer #(.NIBBLES(2), .ADD_LAT(0)) dut1 (
      .clk(clk), .res(res), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .add_x(add_x1), .add_y(add_y1),
      .add_cin(add_cin1), .add_z(add_z1), .add_cout(add_cout1),
      .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
      .carry(carry1), .busy(busy1));

   // Two-stage adder model: output reflects inputs from two edges ago, so a
   // capture before the slot end picks up stale data.
   logic [3:0] x_p1, x_p2, y_p1, y_p2;
   logic       c_p1, c_p2;
   always @(posedge clk) begin
      x_p1 <= add_x0;  x_p2 <= x_p1;
      y_p1 <= add_y0;  y_p2 <= y_p1;
      c_p1 <= add_cin0; c_p2 <= c_p1;
   end
   assign {add_cout0, add_z0} = {1'b0, x_p2} + {1'b0, y_p2} + {4'd0, c_p2};
   assign {add_cout1, add_z1} = {1'b0, add_x1} + {1'b0, add_y1} + {4'd0, add_cin1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one operation on instance 0 and follows it up to DONE (edge 12).
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic [15:0] es, input logic ec, input logic [3:0] cmask,
                         input string tag);
      chk({tag, "/in_ready"}, in_ready0, 1);
      a0 = ta; b0 = tb_v; cin0 = tc; in_valid0 = 1'b1;
      @(posedge clk); #1;
      // junk offered during the operation must be ignored
      a0 = 16'hA5A5; b0 = 16'h5A5A; cin0 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         int k;
         k = c / 3;
         chk($sformatf("%s/ov_c%0d", tag, c), out_valid0, 0);
         chk($sformatf("%s/x_c%0d", tag, c), add_x0, (ta >> (4 * k)) & 16'hF);
         chk($sformatf("%s/y_c%0d", tag, c), add_y0, (tb_v >> (4 * k)) & 16'hF);
         chk($sformatf("%s/cin_c%0d", tag, c), add_cin0, cmask[k]);
         @(posedge clk); #1;
      end
      in_valid0 = 1'b0;
      chk({tag, "/out_valid"}, out_valid0, 1);
      chk({tag, "/sum"}, sum0, es);
      chk({tag, "/carry"}, carry0, ec);
      chk({tag, "/busy"}, busy0, 1);
   endtask

   initial begin
      res = 1'b0;
      in_valid0 = 0; a0 = 0; b0 = 0; cin0 = 0; out_ready0 = 1;
      in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 1;
      #3;
      chk("rst/in_ready", in_ready0, 1);
      chk("rst/busy", busy0, 0);
      chk("rst/out_valid", out_valid0, 0);
      chk("rst/sum", sum0, 0);
      chk("rst/carry", carry0, 0);
      chk("rst/add_x", add_x0, 0);
      @(negedge clk); res = 1'b1;

      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000, "t1");
      @(posedge clk); #1;
      chk("t1/idle", in_ready0, 1);
      chk("t1/ov_low", out_valid0, 0);

      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110, "t2");
      @(posedge clk); #1;

      run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111, "t3");
      @(posedge clk); #1;

      // output held under back-pressure, then no accept on the handshake edge
      out_ready0 = 1'b0;
      run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110, "t4");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("t4/hold_ov%0d", i), out_valid0, 1);
         chk($sformatf("t4/hold_sum%0d", i), sum0, 16'h1000);
         chk($sformatf("t4/hold_carry%0d", i), carry0, 0);
         chk($sformatf("t4/hold_rdy%0d", i), in_ready0, 0);
      end
      a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0; in_valid0 = 1'b1; out_ready0 = 1'b1;
      @(posedge clk); #1;
      chk("t4/hs_in_ready", in_ready0, 1);
      chk("t4/hs_busy", busy0, 0);
      chk("t4/hs_ov", out_valid0, 0);
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      chk("t4/next_busy", busy0, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("t4/next_ov", out_valid0, 1);
      chk("t4/next_sum", sum0, 16'h0003);
      chk("t4/next_carry", carry0, 0);
      @(posedge clk); #1;

      // asynchronous reset in the middle of an operation
      a0 = 16'h1234; b0 = 16'h1111; cin0 = 1'b0; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("t5/pre_busy", busy0, 1);
      res = 1'b0;
      #1;
      chk("t5/ov", out_valid0, 0);
      chk("t5/busy", busy0, 0);
      chk("t5/in_ready", in_ready0, 1);
      chk("t5/sum", sum0, 0);
      chk("t5/carry", carry0, 0);
      chk("t5/add_x", add_x0, 0);
      chk("t5/add_y", add_y0, 0);
      chk("t5/add_cin", add_cin0, 0);
      @(posedge clk);
      @(negedge clk); res = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t5/idle_ov", out_valid0, 0);
      run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 4'b0000, "t5b");
      @(posedge clk); #1;

      // zero-latency adder, two nibbles
      a1 = 8'h8F; b1 = 8'h71; cin1 = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      chk("t6/ov0", out_valid1, 0);
      chk("t6/x0", add_x1, 4'hF);
      chk("t6/cin0", add_cin1, 0);
      @(posedge clk); #1;
      chk("t6/ov1", out_valid1, 0);
      chk("t6/x1", add_x1, 4'h8);
      chk("t6/cin1", add_cin1, 1);
      @(posedge clk); #1;
      chk("t6/ov2", out_valid1, 1);
      chk("t6/sum", sum1, 8'h00);
      chk("t6/carry", carry1, 1);
      chk("t6/add_x_done", add_x1, 0);
      @(posedge clk); #1;
      chk("t6/idle", in_ready1, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
